// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state encoding for the instruction-memory loader
// Contents:
//   ADDR_W_DEFAULT  default instruction-memory address width (depth = 2**ADDR_W bytes)
//   SYNC_DEFAULT    default frame start byte
//   state_t, ST_*   loader FSM state encoding
//   is_sync()       frame-start byte test
package imem_loader_pkg;

  localparam int         ADDR_W_DEFAULT = 5;
  localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t ST_HUNT    = 3'd0;
  localparam state_t ST_ADDR    = 3'd1;
  localparam state_t ST_LEN     = 3'd2;
  localparam state_t ST_DATA    = 3'd3;
  localparam state_t ST_CSUM    = 3'd4;
  localparam state_t ST_RELEASE = 3'd5;
  localparam state_t ST_RUN     = 3'd6;

  function automatic logic is_sync(input logic [7:0] b, input logic [7:0] sync);
    return b == sync;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction-memory write port and CPU control out
// Signals:
//   in_valid, in_data[7:0]   stream byte offered by the source
//   in_ready                 loader accepts a byte this cycle
//   mem_we, mem_addr, mem_wdata  instruction-memory write port
//   cpu_hold                 holds the processor in reset while loading
//   done                     one-cycle pulse on a successfully loaded frame
//   error                    sticky checksum failure flag
// Modports: master = stream source / memory side, slave = loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

endinterface

// File: rtl/imem_loader_csum.sv
// rtl/imem_loader_csum.sv - 8-bit running-sum accumulator for loader frames
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        restart the sum (frame start)
//   add          add data into the sum this cycle
//   data[7:0]    byte being added or checked
//   ok           sum + data == 0 mod 256 (data is the candidate check byte)
module imem_loader_csum
  import imem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic       ok
);

  logic [7:0] sum;
  logic [7:0] total;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (add) begin
      sum <= sum + data;
    end
  end

  assign total = sum + data;
  assign ok    = (total == 8'h00);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing the processor's instruction memory
// Frame: SYNC, ADDR, LEN, LEN payload bytes [, CSUM when IMEM_LOADER_CHECKSUM_EN is defined]
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (checksum byte, CSUM state, functional error)
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   imem_loader_if.slave: stream input, memory write port, cpu_hold/done/error
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEFAULT,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
)(
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        cnt;

  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;

  logic              accept;
  logic              frame_start;

  assign accept = bus.in_valid && in_ready_q;

  // SYNC only opens a frame when the loader is idle (HUNT) or the CPU runs
  // (RUN); inside a frame the same byte value is ordinary data.
  assign frame_start = accept && is_sync(bus.in_data, SYNC) &&
                       ((state == ST_HUNT) || (state == ST_RUN));

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER = ST_CSUM;

  logic csum_add;
  logic csum_ok;
  logic error_q;

  assign csum_add = accept &&
                    ((state == ST_ADDR) || (state == ST_LEN) || (state == ST_DATA));

  imem_loader_csum u_csum (
    .clk   (clk),
    .rst   (rst),
    .clear (frame_start),
    .add   (csum_add),
    .data  (bus.in_data),
    .ok    (csum_ok)
  );

  // Sticky until the next frame start; payload already written stays in memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (frame_start) begin
      error_q <= 1'b0;
    end else if ((state == ST_CSUM) && accept && !csum_ok) begin
      error_q <= 1'b1;
    end
  end

  assign bus.error = error_q;
`else
  localparam state_t ST_AFTER = ST_RELEASE;

  assign bus.error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT, ST_RUN: begin
        if (frame_start) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (accept) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (accept) state_nxt = (bus.in_data != 8'd0) ? ST_DATA : ST_AFTER;
      end
      ST_DATA: begin
        if (accept && (cnt == 8'd1)) state_nxt = ST_AFTER;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_nxt = csum_ok ? ST_RELEASE : ST_HUNT;
      end
`endif
      ST_RELEASE: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HUNT;
      ptr         <= '0;
      cnt         <= 8'd0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state <= state_nxt;

      // Outputs are registered, so they are derived from the next state:
      // the RELEASE cycle is the only one with ready low, and done and the
      // CPU release land in that same cycle.
      in_ready_q <= (state_nxt != ST_RELEASE);
      done_q     <= (state_nxt == ST_RELEASE);
      mem_we_q   <= 1'b0;

      if (state_nxt == ST_RELEASE) begin
        cpu_hold_q <= 1'b0;
      end else if (frame_start) begin
        cpu_hold_q <= 1'b1;
      end

      if (accept) begin
        case (state)
          ST_ADDR: begin
            ptr <= ADDR_W'(bus.in_data);
          end
          ST_LEN: begin
            cnt <= bus.in_data;
          end
          ST_DATA: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ptr;
            mem_wdata_q <= bus.in_data;
            ptr         <= ptr + ADDR_W'(1);
            cnt         <= cnt - 8'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  imem_loader_if #(.ADDR_W(5)) bus ();

  imem_loader #(.ADDR_W(5), .SYNC(8'hA5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a byte at a negedge; return at the negedge after the edge that took it.
  task automatic push(input logic [7:0] b);
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 8 && !got; i++) begin
      got = bus.in_ready;
      @(negedge clk);
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic push_n(input logic [7:0] b);
    push(b);
    chk("no_write", 32'(bus.mem_we), 32'd0);
  endtask

  task automatic push_w(input logic [7:0] b, input int a);
    push(b);
    chk("we", 32'(bus.mem_we), 32'd1);
    chk("waddr", 32'(bus.mem_addr), 32'(a));
    chk("wdata", 32'(bus.mem_wdata), 32'(b));
    chk("hold_loading", 32'(bus.cpu_hold), 32'd1);
  endtask

  // Final frame byte: done/release in the next cycle, then back to running.
  task automatic last(input logic [7:0] b, input logic exp_we, input int a);
    push(b);
    chk("last_we", 32'(bus.mem_we), 32'(exp_we));
    if (exp_we) chk("last_waddr", 32'(bus.mem_addr), 32'(a));
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("hold_released", 32'(bus.cpu_hold), 32'd0);
    chk("ready_bubble", 32'(bus.in_ready), 32'd0);
    chk("error_clear", 32'(bus.error), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("ready_back", 32'(bus.in_ready), 32'd1);
    chk("hold_stays_low", 32'(bus.cpu_hold), 32'd0);
    chk("we_idle", 32'(bus.mem_we), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Good frame: A5 04 03 11 22 33; sum 04+03+11+22+33 = 6D, CSUM = 93.
    push_n(8'hA5);
    chk("sync_hold", 32'(bus.cpu_hold), 32'd1);
    push_n(8'h04);
    push_n(8'h03);
    push_w(8'h11, 4);
    push_w(8'h22, 5);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_w(8'h33, 6);
    last(8'h93, 1'b0, 0);

    // Same frame with a wrong CSUM (94): writes happen, error set, CPU held.
    push_n(8'hA5);
    chk("reload_hold", 32'(bus.cpu_hold), 32'd1);
    push_n(8'h04);
    push_n(8'h03);
    push_w(8'h11, 4);
    push_w(8'h22, 5);
    push_w(8'h33, 6);
    push(8'h94);
    chk("bad_error", 32'(bus.error), 32'd1);
    chk("bad_hold", 32'(bus.cpu_hold), 32'd1);
    chk("bad_no_done", 32'(bus.done), 32'd0);
    chk("bad_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bad_error_sticky", 32'(bus.error), 32'd1);
    chk("bad_hold_sticky", 32'(bus.cpu_hold), 32'd1);

    push_n(8'hA5);
    chk("sync_clears_error", 32'(bus.error), 32'd0);
    push_n(8'h04);
    push_n(8'h03);
    push_w(8'h11, 4);
    push_w(8'h22, 5);
    push_w(8'h33, 6);
    last(8'h93, 1'b0, 0);
`else
    last(8'h33, 1'b1, 6);
`endif

    // Wrap: start 1E, four bytes -> 30, 31, 0, 1; CSUM = -(1E+04+01+02+03+04) = D4.
    push_n(8'hA5);
    push_n(8'h1E);
    push_n(8'h04);
    push_w(8'h01, 30);
    push_w(8'h02, 31);
    push_w(8'h03, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_w(8'h04, 1);
    last(8'hD4, 1'b0, 0);
`else
    last(8'h04, 1'b1, 1);
`endif

    // Garbage then zero-length frame.
    push_n(8'h00);
    push_n(8'hFF);
    chk("garbage_no_hold", 32'(bus.cpu_hold), 32'd0);
    push_n(8'hA5);
    chk("zero_len_hold", 32'(bus.cpu_hold), 32'd1);
    push_n(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_n(8'h00);
`endif
    last(8'h00, 1'b0, 0);

    // Reload, then reset in the middle of the payload.
    push_n(8'hA5);
    chk("run_sync_hold", 32'(bus.cpu_hold), 32'd1);
    push_n(8'h04);
    push_n(8'h02);
    push_w(8'h55, 4);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("mid_rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // Fresh frame after reset: A5 08 02 AA BB; CSUM = -(08+02+AA+BB) = 91.
    push_n(8'hA5);
    push_n(8'h08);
    push_n(8'h02);
    push_w(8'hAA, 8);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_w(8'hBB, 9);
    last(8'h91, 1'b0, 0);
`else
    last(8'hBB, 1'b1, 9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
